nonce_search_ctrl: RTL and testbench
====================================

Name: nonce_search_ctrl

Overview:
- Drives the 256-bit nonce input of the free-running, fixed-latency SHA-256 hash pipeline and consumes its digests.
- Issues one candidate nonce per cycle, starting from a base nonce.
- Matches each returning digest to the nonce that produced it by counting, and compares the digest against a 256-bit target.
- Reports the first nonce whose digest is strictly below the target, or reports exhaustion. Sits between the host/control logic and the hash pipeline.

Parameters:
- LATENCY, 65: cycles from nonce presented on hash_nonce to its digest on hash_digest; must be at least 1.
- CNT_W, 32: width of the attempt and return counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a search. Accepted only in IDLE or DONE.
- base_nonce  in  256  first nonce of the search; latched on accepted start.
- target  in  256  unsigned threshold; latched on accepted start.
- max_attempts  in  CNT_W  number of nonces to try; latched on accepted start.
- hash_nonce  out  256  nonce fed to the hash pipeline input.
- hash_digest  in  256  digest from the hash pipeline output.
- busy  out  1  high while in ISSUE or DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.
- found  out  1  sticky hit flag; valid when done pulses; cleared on the next accepted start.
- found_nonce  out  256  nonce that produced the hit; holds until the next accepted start.
- found_digest  out  256  digest that produced the hit; holds until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; all counters 0; valid shift register cleared. Outputs: busy=0, done=0, found=0, found_nonce=0, found_digest=0, hash_nonce=0. Reset mid-search abandons the search; in-flight digests are ignored.
- All outputs are registered. Arithmetic is unsigned. Nonce addition is a full 256-bit add, mod 2^256.
- States: IDLE, ISSUE, DRAIN, DONE.
- Accepted start (IDLE or DONE):
  - Latch base_nonce, target and max_attempts.
  - Clear issued_cnt, ret_cnt, found, found_nonce and found_digest.
  - If max_attempts==0, go directly to DONE (done pulses the next cycle, found=0). Otherwise go to ISSUE.
- start while busy: ignored.
- ISSUE, each cycle:
  - hash_nonce <= base + issued_cnt.
  - Push 1 into the LATENCY-deep valid shift register; issued_cnt++.
  - When issued_cnt reaches max_attempts, go to DRAIN; later cycles push 0.
- Return path, every cycle while busy:
  - The shift register output marks hash_digest as belonging to nonce base + ret_cnt. The first nonce is issued at cycle t0 and its digest is sampled at t0+LATENCY.
  - On a valid return: if hash_digest < target, it is a hit. Set found=1, found_nonce=base+ret_cnt, found_digest=hash_digest, stop issuing, clear the valid shift register, and go to DONE. Otherwise ret_cnt++.
  - digest==target is not a hit; target=0 never hits.
- DRAIN: no new valid entries. Go to DONE when ret_cnt==issued_cnt without a hit. A hit during DRAIN is handled as in ISSUE.
- Hit and last return in the same cycle: the hit wins, found=1.
- DONE: done=1 for exactly the entry cycle, then 0. busy=0. hash_nonce holds its last value. Waits for start.
- Only the first hit is reported; later digests are discarded.
- max_attempts=2^CNT_W-1 must complete without counter overflow.
- Latency from last issue to done is LATENCY+1 cycles in the no-hit case.

Test Plan:
- base=0, max_attempts=4, target=all-ones → nonce 0 hits; found=1, found_nonce=0, done exactly LATENCY+1 cycles after the first issue; busy low afterwards.
- base=100, max_attempts=8, target=0 → hash_nonce steps 100..107 on consecutive cycles; no hit; done pulses LATENCY+1 cycles after issuing 107; found=0.
- Bench model returns digest=0 only for nonce 103 (base=100, target=1) → found_nonce=103, found_digest=0; later digests ignored; issuing stops within 1 cycle of the hit.
- Digest equal to target for every nonce, max_attempts=3 → no hit, found=0; then start again with target=digest+1 → found_nonce=base.
- base=2^256-2, max_attempts=4 → hash_nonce sequence is 2^256-2, 2^256-1, 0, 1 (wrap); done pulses, found=0.
- rst_n=0 for one cycle mid-ISSUE → all outputs 0, state IDLE, digests arriving afterwards raise no hit. start during busy is ignored. max_attempts=0 → done on the next cycle with found=0.

Source files
------------

// File: rtl/nonce_search_ctrl_if.sv
// Host and hash-pipeline signals of the nonce search controller, bundled as one interface.
// Latency: none, wires only.
// Backpressure: none. The hash pipeline is free-running and the host handshake is a start pulse.
interface nonce_search_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [255:0]     base_nonce;
    logic [255:0]     target;
    logic [CNT_W-1:0] max_attempts;
    logic [255:0]     hash_nonce;
    logic [255:0]     hash_digest;
    logic             busy;
    logic             done;
    logic             found;
    logic [255:0]     found_nonce;
    logic [255:0]     found_digest;

    // Environment side: host controls plus the hash pipeline output.
    modport master (
        output start, base_nonce, target, max_attempts, hash_digest,
        input  hash_nonce, busy, done, found, found_nonce, found_digest
    );

    // Controller side.
    modport slave (
        input  start, base_nonce, target, max_attempts, hash_digest,
        output hash_nonce, busy, done, found, found_nonce, found_digest
    );
endinterface

// File: rtl/nonce_search_ctrl.sv
// Feeds consecutive nonces to a fixed-latency hash pipeline and reports the first digest below target.
// Latency: one nonce per cycle. done comes LATENCY+1 cycles after the last issue, or the cycle after a hit is sampled.
// Backpressure: none. start is ignored while busy. The pipeline cannot stall, so returns are matched by counting.
module nonce_search_ctrl #(
    parameter int LATENCY = 65,   // hash_nonce -> hash_digest delay in cycles, >= 1
    parameter int CNT_W   = 32    // must match the interface CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    nonce_search_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state;
    logic [255:0]       base_q;
    logic [255:0]       target_q;
    logic [CNT_W-1:0]   max_q;
    logic [CNT_W-1:0]   issued_cnt;
    logic [CNT_W-1:0]   ret_cnt;
    // issue_q marks that hash_nonce holds a freshly issued nonce this cycle.
    // vld_sr delays that mark by the pipeline depth, so its MSB lines up with hash_digest.
    logic               issue_q;
    logic [LATENCY-1:0] vld_sr;

    logic [255:0]       hash_nonce_q;
    logic [255:0]       found_nonce_q;
    logic [255:0]       found_digest_q;
    logic               busy_q;
    logic               done_q;
    logic               found_q;

    logic               ret_vld;
    logic               is_hit;

    assign ret_vld = vld_sr[LATENCY-1];
    assign is_hit  = ret_vld && (bus.hash_digest < target_q);

    assign bus.hash_nonce   = hash_nonce_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.found        = found_q;
    assign bus.found_nonce  = found_nonce_q;
    assign bus.found_digest = found_digest_q;

    // Search FSM: issue nonces, count returning digests, and stop on the first hit or on exhaustion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_q         <= '0;
            target_q       <= '0;
            max_q          <= '0;
            issued_cnt     <= '0;
            ret_cnt        <= '0;
            issue_q        <= 1'b0;
            vld_sr         <= '0;
            hash_nonce_q   <= '0;
            found_nonce_q  <= '0;
            found_digest_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            found_q        <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            issue_q <= 1'b0;
            // Shift form that still works when LATENCY is 1.
            vld_sr  <= (vld_sr << 1) | LATENCY'(issue_q);
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        base_q         <= bus.base_nonce;
                        target_q       <= bus.target;
                        max_q          <= bus.max_attempts;
                        issued_cnt     <= '0;
                        ret_cnt        <= '0;
                        vld_sr         <= '0;
                        found_q        <= 1'b0;
                        found_nonce_q  <= '0;
                        found_digest_q <= '0;
                        if (bus.max_attempts == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            state  <= ISSUE;
                            busy_q <= 1'b1;
                        end
                    end
                end
                ISSUE, DRAIN: begin
                    if (is_hit) begin
                        // A hit beats a same-cycle issue or a same-cycle final return.
                        // Clearing the valid marks drops every digest still in flight.
                        found_q        <= 1'b1;
                        found_nonce_q  <= base_q + 256'(ret_cnt);
                        found_digest_q <= bus.hash_digest;
                        vld_sr         <= '0;
                        issue_q        <= 1'b0;
                        state          <= DONE;
                        done_q         <= 1'b1;
                        busy_q         <= 1'b0;
                    end else begin
                        if (ret_vld) begin
                            ret_cnt <= ret_cnt + CNT_W'(1);
                        end
                        if (state == ISSUE) begin
                            hash_nonce_q <= base_q + 256'(issued_cnt);
                            issue_q      <= 1'b1;
                            issued_cnt   <= issued_cnt + CNT_W'(1);
                            // max_q is at most 2^CNT_W-1, so this increment never wraps.
                            if (issued_cnt + CNT_W'(1) == max_q) begin
                                state <= DRAIN;
                            end
                        end else if (ret_vld && (ret_cnt + CNT_W'(1) == issued_cnt)) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Self-checking bench for nonce_search_ctrl, driving it through a behavioural hash pipeline model.
// Expected results come from a plain linear search over base+i, plus cycle arithmetic.
module tb_nonce_search_ctrl;
    localparam int LAT = 65;
    localparam int CW  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nonce_search_ctrl_if #(.CNT_W(CW)) bus();

    nonce_search_ctrl #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Digest model. Mode 0 scrambles the nonce, mode 1 gives a zero digest only for 'special',
    // and mode 2 returns a constant digest.
    int           dmode = 0;
    logic [255:0] special = '0;
    logic [255:0] const_dig = '0;

    function automatic logic [255:0] digest_of(input logic [255:0] n);
        logic [31:0] h;
        case (dmode)
            1: return (n == special) ? '0 : '1;
            2: return const_dig;
            default: begin
                h = (n[31:0] * 32'h9E3779B1) ^ n[63:32] ^ n[255:224];
                return {h, n[223:0] ^ {7{32'h5BD1E995}}};
            end
        endcase
    endfunction

    // Free-running hash pipeline: the digest of hash_nonce appears LAT cycles later.
    logic [255:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= digest_of(bus.hash_nonce);
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign bus.hash_digest = pipe[LAT-1];

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
        chk({tag, "_done"}, 256'(bus.done), 256'(0));
        chk({tag, "_found"}, 256'(bus.found), 256'(0));
        chk({tag, "_fnonce"}, bus.found_nonce, '0);
        chk({tag, "_fdigest"}, bus.found_digest, '0);
        chk({tag, "_hnonce"}, bus.hash_nonce, '0);
    endtask

    // Run one search. If poke > 0, a conflicting start is pulsed in that cycle while busy.
    task automatic run_search(input logic [255:0] b, input logic [255:0] t,
                              input logic [CW-1:0] m, input int poke, input string tag);
        logic         hit;
        longint       hi;
        logic [255:0] hd;
        logic [255:0] dg;
        longint       last_issue;
        longint       exp_d;
        longint       d_at;
        logic         seq_ok;
        logic         busy_ok;
        logic [255:0] seq_obs;
        logic [255:0] seq_exp;
        logic [255:0] exp_hn;

        // Reference: first i in [0,m) with digest(b+i) < t.
        hit = 1'b0;
        hi  = 0;
        hd  = '0;
        for (longint i = 0; i < longint'(m) && !hit && i < 4096; i++) begin
            dg = digest_of(b + 256'(i));
            if (dg < t) begin
                hit = 1'b1;
                hi  = i;
                hd  = dg;
            end
        end
        exp_d      = hit ? hi + LAT + 2 : longint'(m) + LAT + 1;
        last_issue = hit ? ((longint'(m) < hi + LAT + 1) ? longint'(m) : hi + LAT + 1) : longint'(m);

        bus.base_nonce   = b;
        bus.target       = t;
        bus.max_attempts = m;
        bus.start        = 1'b1;
        tick();
        bus.start      = 1'b0;
        bus.base_nonce = rand256();
        bus.target     = rand256();

        if (m == '0) begin
            chk({tag, "_zero_done"}, 256'(bus.done), 256'(1));
            chk({tag, "_zero_found"}, 256'(bus.found), 256'(0));
            chk({tag, "_zero_busy"}, 256'(bus.busy), 256'(0));
            tick();
            chk({tag, "_zero_pulse"}, 256'(bus.done), 256'(0));
            return;
        end

        chk({tag, "_busy_start"}, 256'(bus.busy), 256'(1));
        seq_ok  = 1'b1;
        busy_ok = 1'b1;
        seq_obs = '0;
        seq_exp = '0;
        d_at    = -1;
        for (longint k = 1; k <= exp_d + 20; k++) begin
            bus.start = (k == poke);
            if (k == poke) begin
                bus.max_attempts = '0;
                bus.target       = '1;
            end
            tick();
            bus.start = 1'b0;
            exp_hn = b + 256'(((k < last_issue) ? k : last_issue) - 1);
            if (seq_ok && bus.hash_nonce !== exp_hn) begin
                seq_ok  = 1'b0;
                seq_obs = bus.hash_nonce;
                seq_exp = exp_hn;
            end
            if (bus.done) begin
                d_at = k;
                break;
            end
            if (bus.busy !== 1'b1 || bus.found !== 1'b0) busy_ok = 1'b0;
        end
        if (seq_ok) begin
            seq_obs = bus.hash_nonce;
            seq_exp = b + 256'(last_issue - 1);
        end
        chk({tag, "_nonce_seq"}, seq_obs, seq_exp);
        chk({tag, "_busy_during"}, 256'(busy_ok), 256'(1));
        chk({tag, "_done_cycle"}, 256'(d_at), 256'(exp_d));
        chk({tag, "_found"}, 256'(bus.found), 256'(hit));
        chk({tag, "_fnonce"}, bus.found_nonce, hit ? b + 256'(hi) : '0);
        chk({tag, "_fdigest"}, bus.found_digest, hit ? hd : '0);
        chk({tag, "_busy_end"}, 256'(bus.busy), 256'(0));
        for (int w = 0; w < 3; w++) tick();
        chk({tag, "_pulse"}, 256'(bus.done), 256'(0));
        chk({tag, "_fnonce_hold"}, bus.found_nonce, hit ? b + 256'(hi) : '0);
        chk({tag, "_hnonce_hold"}, bus.hash_nonce, b + 256'(last_issue - 1));
    endtask

    initial begin
        logic [255:0] b;
        logic [255:0] t;
        logic [CW-1:0] m;
        logic          bad;

        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.base_nonce   = '0;
        bus.target       = '0;
        bus.max_attempts = '0;
        for (int i = 0; i < 3; i++) tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // max_attempts of zero goes straight to DONE.
        run_search(256'd7, '1, '0, 0, "zero_attempts");

        // Any digest below all-ones means nonce 0 hits immediately.
        dmode = 0;
        run_search('0, '1, 4, 0, "first_hit");

        // A target of zero can never be hit.
        run_search(256'd100, '0, 8, 0, "no_hit");

        // Only nonce 103 returns a digest below the target.
        dmode   = 1;
        special = 256'd103;
        run_search(256'd100, 256'd1, 20, 0, "hit_103");

        // A digest equal to the target is not a hit. target=digest+1 hits nonce base.
        dmode     = 2;
        const_dig = rand256();
        const_dig[255] = 1'b0;
        b = rand256();
        run_search(b, const_dig, 3, 0, "eq_target");
        run_search(b, const_dig + 256'd1, 3, 0, "eq_plus1");

        // Reset in the middle of ISSUE abandons the search, and late digests are ignored.
        dmode = 0;
        bus.base_nonce   = rand256();
        bus.target       = '1;
        bus.max_attempts = 50;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle_outputs("mid_reset");
        bad = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (bus.done || bus.found || bus.busy) bad = 1'b1;
        end
        chk("mid_reset_quiet", 256'(bad), 256'(0));

        // The nonce sequence wraps through 2^256.
        dmode = 0;
        run_search('1 - 256'd1, '0, 4, 0, "wrap");

        // A start while busy is ignored.
        run_search(256'd500, '0, 6, 3, "start_busy");
        dmode   = 1;
        special = 256'd1003;
        run_search(256'd1000, 256'd1, 10, 40, "start_busy_hit");

        // The largest max_attempts value still finds an early hit.
        b       = rand256();
        special = b + 256'd9;
        run_search(b, 256'd1, '1, 0, "max_cnt");

        // Random searches against the scrambling digest.
        dmode = 0;
        for (int r = 0; r < 6; r++) begin
            b = rand256();
            t = {$urandom_range(32'h2000_0000, 0), 224'd0};
            m = CW'($urandom_range(40, 1));
            run_search(b, t, m, 0, $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
